// File: rtl/ccc_clk_div_gen_if.sv
// Configuration and status bundle of the clock divider generator.
// master drives CFG_WE/CFG_SEL/CFG_DIV and observes per-channel status.
interface ccc_clk_div_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = 2
);
    logic              CFG_WE;
    logic [SEL_W-1:0]  CFG_SEL;
    logic [DIV_W-1:0]  CFG_DIV;
    logic              CFG_ERR;
    logic [NUM_CH-1:0] CH_PEND;
    logic [NUM_CH-1:0] CE;
    logic [NUM_CH-1:0] CLKOUT;
    logic [NUM_CH-1:0] LOCK;
    logic              ALL_LOCK;

    modport master (
        output CFG_WE, CFG_SEL, CFG_DIV,
        input  CFG_ERR, CH_PEND, CE, CLKOUT, LOCK, ALL_LOCK
    );

    modport slave (
        input  CFG_WE, CFG_SEL, CFG_DIV,
        output CFG_ERR, CH_PEND, CE, CLKOUT, LOCK, ALL_LOCK
    );
endinterface

// File: rtl/ccc_clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator with glitch-free
// run-time divisor changes and per-channel lock.
// Ports: CLK (GLA0), RESETN (async active-low), bus (slave): CFG_WE/SEL/DIV
// write port; CFG_ERR, CH_PEND, CE, CLKOUT, LOCK, ALL_LOCK status outputs.
module ccc_clk_div_gen #(
    parameter int NUM_CH       = 4,
    parameter int DIV_W        = 8,
    parameter int DEFAULT_DIV  = 2,
    parameter int LOCK_PERIODS = 4,
    parameter int SEL_W        = 2
) (
    input logic               CLK,
    input logic               RESETN,
    ccc_clk_div_gen_if.slave  bus
);
    localparam int LC_W = $clog2(LOCK_PERIODS + 1);

    logic              sel_ok;
    logic              err_q;
    logic              all_q;
    logic [NUM_CH-1:0] lock_v;

    assign sel_ok = 32'(bus.CFG_SEL) < NUM_CH;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_act;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_pend;
        logic             pend_valid;
        logic [LC_W-1:0]  lock_cnt;
        logic [LC_W-1:0]  lock_nxt;
        logic             ce_q;
        logic             clk_q;
        logic             lock_q;
        logic             run;
        logic             wrap;
        logic             apply;
        logic             wr;
        logic [DIV_W:0]   half;

        assign run   = div_act != '0;
        assign wrap  = run && (cnt == div_act - 1'b1);
        // A stopped channel has no period boundary to wait for.
        assign apply = pend_valid && (!run || wrap);
        assign wr    = bus.CFG_WE && sel_ok && (32'(bus.CFG_SEL) == i);
        // High phase is the rounded-up half so odd ratios favour high.
        assign half  = ({1'b0, div_act} + 1'b1) >> 1;

        assign lock_nxt = (wrap && lock_cnt < LC_W'(LOCK_PERIODS))
                        ? lock_cnt + 1'b1 : lock_cnt;

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                div_act    <= DIV_W'(DEFAULT_DIV);
                cnt        <= '0;
                div_pend   <= '0;
                pend_valid <= 1'b0;
                lock_cnt   <= '0;
                ce_q       <= 1'b0;
                clk_q      <= 1'b0;
                lock_q     <= 1'b0;
            end else begin
                ce_q  <= wrap;
                clk_q <= run && ({1'b0, cnt} < half);
                // A write landing on the apply cycle stays pending for
                // the next boundary; the apply uses the older value.
                if (wr) begin
                    div_pend   <= bus.CFG_DIV;
                    pend_valid <= 1'b1;
                end else if (apply) begin
                    pend_valid <= 1'b0;
                end
                if (apply) begin
                    div_act  <= div_pend;
                    cnt      <= '0;
                    lock_cnt <= '0;
                    lock_q   <= 1'b0;
                end else begin
                    cnt      <= (wrap || !run) ? '0 : cnt + 1'b1;
                    lock_cnt <= lock_nxt;
                    lock_q   <= lock_nxt == LC_W'(LOCK_PERIODS);
                end
            end
        end

        assign bus.CE[i]      = ce_q;
        assign bus.CLKOUT[i]  = clk_q;
        assign bus.CH_PEND[i] = pend_valid;
        assign lock_v[i]      = lock_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            err_q <= 1'b0;
            all_q <= 1'b0;
        end else begin
            err_q <= bus.CFG_WE && !sel_ok;
            all_q <= &lock_v;
        end
    end

    assign bus.LOCK     = lock_v;
    assign bus.CFG_ERR  = err_q;
    assign bus.ALL_LOCK = all_q;
endmodule

// File: tb/tb_ccc_clk_div_gen.sv
// Self-checking bench for ccc_clk_div_gen: directed scenarios plus
// random writes against a period-level reference model.
module tb_ccc_clk_div_gen;
    localparam int NCH = 4;
    localparam int DEF = 2;
    localparam int LP  = 4;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errs = 0;
    int   k = 0;

    always #5 clk = ~clk;

    ccc_clk_div_gen_if #(.NUM_CH(NCH), .DIV_W(8), .SEL_W(2)) bus ();
    ccc_clk_div_gen_if #(.NUM_CH(3), .DIV_W(8), .SEL_W(2)) bus2 ();

    ccc_clk_div_gen #(
        .NUM_CH(NCH), .DIV_W(8), .DEFAULT_DIV(DEF),
        .LOCK_PERIODS(LP), .SEL_W(2)
    ) dut (
        .CLK(clk), .RESETN(rstn), .bus(bus)
    );

    ccc_clk_div_gen #(
        .NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(DEF),
        .LOCK_PERIODS(LP), .SEL_W(2)
    ) dut3 (
        .CLK(clk), .RESETN(rstn), .bus(bus2)
    );

    // Reference model: ratio, position within the period, pending write,
    // completed periods at the current ratio.
    int m_div[NCH];
    int m_pos[NCH];
    int m_pdiv[NCH];
    int m_per[NCH];
    bit m_pend[NCH];
    logic [NCH-1:0] m_ce, m_clk, m_lock, m_pv;
    logic m_err, m_all;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c] = DEF; m_pos[c] = 0; m_pdiv[c] = 0;
            m_per[c] = 0; m_pend[c] = 0;
        end
        m_ce = '0; m_clk = '0; m_lock = '0; m_pv = '0;
        m_err = 0; m_all = 0;
    endfunction

    function automatic void model_step(input bit we, input int sel,
                                       input int dv);
        int d;
        bit last, app;
        m_all = &m_lock;
        m_err = we && sel >= NCH;
        for (int c = 0; c < NCH; c++) begin
            d = m_div[c];
            last = d != 0 && m_pos[c] == d - 1;
            app = m_pend[c] && (d == 0 || last);
            m_ce[c] = last;
            m_clk[c] = d != 0 && m_pos[c] < (d + 1) / 2;
            if (app) begin
                m_div[c] = m_pdiv[c]; m_pos[c] = 0; m_per[c] = 0;
            end else begin
                if (d != 0) m_pos[c] = (m_pos[c] + 1) % d;
                if (last && m_per[c] < LP) m_per[c]++;
            end
            m_lock[c] = m_div[c] != 0 && m_per[c] >= LP;
            if (we && sel == c) begin
                m_pdiv[c] = dv; m_pend[c] = 1;
            end else if (app) begin
                m_pend[c] = 0;
            end
            m_pv[c] = m_pend[c];
        end
    endfunction

    // One clock: drive inputs, advance model, sample at the falling edge.
    task automatic tick(input bit we, input int sel, input int dv);
        bus.CFG_WE = we;
        bus.CFG_SEL = 2'(sel);
        bus.CFG_DIV = 8'(dv);
        model_step(we, sel, dv);
        @(posedge clk);
        k++;
        @(negedge clk);
        bus.CFG_WE = 1'b0;
        bus2.CFG_WE = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND, bus.CFG_ERR,
             bus.ALL_LOCK} !== '0) begin
            errs++;
            $display("FAIL reset_outs: got %b exp 0",
                     {bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND});
        end
        rstn = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.LOCK !== m_lock || bus.ALL_LOCK !== m_all) begin
                errs++;
                $display("FAIL reset_run k=%0d: got %b %b %b %b exp %b %b %b %b",
                         k, bus.CE, bus.CLKOUT, bus.LOCK, bus.ALL_LOCK,
                         m_ce, m_clk, m_lock, m_all);
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (bus.LOCK !== (k == 8 ? 4'hf : 4'h0)
                    || bus.ALL_LOCK !== 1'b0) begin
                    errs++;
                    $display("FAIL lock_edge k=%0d: got %b/%b",
                             k, bus.LOCK, bus.ALL_LOCK);
                end
            end
            if (k == 9) begin
                checks++;
                if (bus.ALL_LOCK !== 1'b1) begin
                    errs++;
                    $display("FAIL all_lock k=9: got %b exp 1", bus.ALL_LOCK);
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        tick(1, 1, 5);
        checks++;
        if (bus.CH_PEND !== 4'b0010) begin
            errs++;
            $display("FAIL ratio_pend: got %b exp 0010", bus.CH_PEND);
        end
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.LOCK !== m_lock || bus.CH_PEND !== m_pv) begin
                errs++;
                $display("FAIL ratio_run: got %b %b %b %b exp %b %b %b %b",
                         bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND,
                         m_ce, m_clk, m_lock, m_pv);
            end
        end
    endtask

    task automatic test_stop_restart();
        tick(1, 2, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        checks++;
        if (bus.CE[2] !== 1'b0 || bus.CLKOUT[2] !== 1'b0
            || bus.LOCK[2] !== 1'b0) begin
            errs++;
            $display("FAIL stop: got ce=%b clk=%b lock=%b exp 0",
                     bus.CE[2], bus.CLKOUT[2], bus.LOCK[2]);
        end
        tick(1, 2, 3);
        checks++;
        if (bus.CH_PEND[2] !== 1'b1) begin
            errs++;
            $display("FAIL restart_pend: got %b exp 1", bus.CH_PEND[2]);
        end
        tick(0, 0, 0);
        checks++;
        if (bus.CH_PEND[2] !== 1'b0) begin
            errs++;
            $display("FAIL restart_apply: got %b exp 0", bus.CH_PEND[2]);
        end
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.LOCK !== m_lock) begin
                errs++;
                $display("FAIL restart_run: got %b %b %b exp %b %b %b",
                         bus.CE, bus.CLKOUT, bus.LOCK, m_ce, m_clk, m_lock);
            end
        end
    endtask

    task automatic test_last_write_wins();
        int n;
        int p[$];
        tick(1, 0, 6);
        n = 0;
        while (m_div[0] != 6 && n < 10) begin
            tick(0, 0, 0);
            n++;
        end
        n = 0;
        while (m_pos[0] != 1 && n < 10) begin
            tick(0, 0, 0);
            n++;
        end
        tick(1, 0, 7);
        tick(1, 0, 9);
        checks++;
        if (bus.CFG_ERR !== 1'b0 || bus.CH_PEND[0] !== 1'b1) begin
            errs++;
            $display("FAIL lww_pend: err=%b pend=%b exp 0/1",
                     bus.CFG_ERR, bus.CH_PEND[0]);
        end
        n = 0;
        while (m_div[0] != 9 && n < 20) begin
            tick(0, 0, 0);
            n++;
        end
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0);
            if (bus.CE[0] === 1'b1) p.push_back(k);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.CFG_ERR !== 1'b0) begin
                errs++;
                $display("FAIL lww_run: got %b %b %b exp %b %b 0",
                         bus.CE, bus.CLKOUT, bus.CFG_ERR, m_ce, m_clk);
            end
        end
        checks++;
        if (p.size() < 2 || p[1] - p[0] != 9) begin
            errs++;
            $display("FAIL lww_period: got %0d pulses exp period 9",
                     p.size());
        end
    endtask

    task automatic test_bad_sel();
        bus2.CFG_WE = 1'b1;
        bus2.CFG_SEL = 2'd3;
        bus2.CFG_DIV = 8'd5;
        tick(0, 0, 0);
        checks++;
        if (bus2.CFG_ERR !== 1'b1 || bus2.CH_PEND !== 3'b000) begin
            errs++;
            $display("FAIL bad_sel: err=%b pend=%b exp 1/000",
                     bus2.CFG_ERR, bus2.CH_PEND);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus2.CFG_ERR !== 1'b0 || bus2.CH_PEND !== 3'b000
                || bus2.CE !== {3{k % 2 == 0}}
                || bus2.CLKOUT !== {3{k % 2 == 1}}
                || bus2.LOCK !== 3'b111) begin
                errs++;
                $display("FAIL bad_sel_run: err=%b pend=%b ce=%b clk=%b lock=%b",
                         bus2.CFG_ERR, bus2.CH_PEND, bus2.CE,
                         bus2.CLKOUT, bus2.LOCK);
            end
        end
    endtask

    task automatic test_wrap_write();
        int n;
        n = 0;
        while ((m_div[3] == 0 || m_pos[3] != m_div[3] - 1) && n < 20) begin
            tick(0, 0, 0);
            n++;
        end
        tick(1, 3, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.LOCK !== m_lock || bus.CH_PEND !== m_pv) begin
                errs++;
                $display("FAIL wrap_write: got %b %b %b %b exp %b %b %b %b",
                         bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND,
                         m_ce, m_clk, m_lock, m_pv);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus.CE[3] !== 1'b1 || bus.CLKOUT[3] !== 1'b1) begin
                errs++;
                $display("FAIL div1: got ce=%b clk=%b exp 1/1",
                         bus.CE[3], bus.CLKOUT[3]);
            end
        end
    endtask

    task automatic test_random();
        bit we;
        int sel, dv;
        for (int i = 0; i < 600; i++) begin
            we = $urandom_range(0, 5) == 0;
            sel = $urandom_range(0, NCH - 1);
            dv = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 8);
            tick(we, sel, dv);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.LOCK !== m_lock || bus.CH_PEND !== m_pv
                || bus.ALL_LOCK !== m_all || bus.CFG_ERR !== m_err) begin
                errs++;
                $display("FAIL random i=%0d: got %b %b %b %b %b exp %b %b %b %b %b",
                         i, bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND,
                         bus.ALL_LOCK, m_ce, m_clk, m_lock, m_pv, m_all);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 0, 5);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND, bus.ALL_LOCK,
             bus2.CE, bus2.CLKOUT, bus2.LOCK} !== '0) begin
            errs++;
            $display("FAIL async_reset: got %b %b %b %b",
                     bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND);
        end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0);
            checks++;
            if (bus.CE !== m_ce || bus.CLKOUT !== m_clk
                || bus.LOCK !== m_lock || bus.CH_PEND !== 4'b0000) begin
                errs++;
                $display("FAIL after_reset: got %b %b %b %b exp %b %b %b 0000",
                         bus.CE, bus.CLKOUT, bus.LOCK, bus.CH_PEND,
                         m_ce, m_clk, m_lock);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.CFG_WE = 1'b0; bus.CFG_SEL = '0; bus.CFG_DIV = '0;
        bus2.CFG_WE = 1'b0; bus2.CFG_SEL = '0; bus2.CFG_DIV = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_ratio_change();
        test_stop_restart();
        test_last_write_wins();
        test_bad_sel();
        test_wrap_write();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule

// File: doc/ccc_clk_div_gen.md
Name: ccc_clk_div_gen

Overview:
- Parametrised multi-channel clock-enable and divided-clock generator, fed by the CCC global clock (GLA0 from the MSS CCC).
- Replaces fixed, hard-configured CCC divider settings with per-channel divisors that can be changed at run time.
- Ratio changes take effect only at a period boundary, so they never glitch.
- Each channel has its own lock indication, plus an aggregate lock; fabric peripherals use the per-channel enables/lock as their clock qualifiers.

Parameters:
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 8, divisor width in bits
- DEFAULT_DIV, 2, active divisor loaded into every channel at reset (0 = stopped)
- LOCK_PERIODS, 4, complete periods at a new ratio before LOCK asserts (>=1)
- SEL_W, 2, CFG_SEL width; must satisfy 2**SEL_W >= NUM_CH

Ports:
- CLK  in  1  source clock (GLA0); all logic on rising edge
- RESETN  in  1  asynchronous, active-low reset
- CFG_WE  in  1  divisor write strobe, one cycle per write
- CFG_SEL  in  SEL_W  channel index for the write
- CFG_DIV  in  DIV_W  new divisor value
- CFG_ERR  out  1  one-cycle pulse: write with CFG_SEL >= NUM_CH (ignored)
- CH_PEND  out  NUM_CH  per channel: written divisor not yet applied
- CE  out  NUM_CH  per-channel clock enable, one CLK cycle high per period
- CLKOUT  out  NUM_CH  per-channel divided square wave (registered)
- LOCK  out  NUM_CH  per-channel: ratio stable for LOCK_PERIODS periods
- ALL_LOCK  out  1  AND of LOCK

Behaviour:
- Reset (async assert, sync release), per channel:
  - div_act=DEFAULT_DIV, cnt=0, div_pend=0, pend_valid=0, lock_cnt=0.
  - All outputs 0: CE=0, CLKOUT=0, LOCK=0, CH_PEND=0, CFG_ERR=0, ALL_LOCK=0.
- Counter:
  - If div_act != 0: cnt counts 0..div_act-1 and wraps to 0. "Wrap cycle" = the cycle with cnt==div_act-1.
  - If div_act == 0: cnt is held at 0.
- Outputs are registered from state, one cycle after the cnt value that produces them:
  - CE <= (div_act!=0) && (cnt==div_act-1). Period is exactly div_act cycles.
  - CLKOUT <= (div_act!=0) && (cnt < (div_act+1)>>1). Odd divisors are high one cycle longer than low. div_act=1 gives CLKOUT constantly 1 and CE constantly 1.
- Write:
  - CFG_WE with valid SEL: div_pend <= CFG_DIV, pend_valid <= 1 (CH_PEND high the next cycle). A later write before apply overwrites div_pend (last write wins).
  - Invalid SEL: no state change; CFG_ERR=1 the next cycle.
- Apply, evaluated on the registered pend_valid:
  - If div_act==0: apply on the first cycle pend_valid=1.
  - Else: apply on the wrap cycle.
  - On apply: div_act <= div_pend, cnt <= 0, pend_valid <= 0, lock_cnt <= 0, LOCK <= 0.
  - A write in the same cycle as a wrap is not applied at that wrap; it applies at the next wrap.
  - A write of the value already active is still applied (LOCK drops and re-locks).
- Lock:
  - lock_cnt increments on each wrap cycle (saturating) while div_act != 0 and no apply occurs.
  - LOCK <= 1 on the cycle lock_cnt reaches LOCK_PERIODS.
  - div_act==0 keeps LOCK=0.
  - Reset state behaves as a fresh apply of DEFAULT_DIV, so LOCK asserts after LOCK_PERIODS periods following reset.
- ALL_LOCK is a registered AND of the LOCK vector (one further cycle).
- Reset mid-operation clears everything immediately; the pending write is lost.
- Channels are fully independent; one write affects only the selected channel.

Test Plan:
- Reset release, DEFAULT_DIV=2, LOCK_PERIODS=4 -> every CE pulses every 2 cycles; CLKOUT is 1 cycle high / 1 low; LOCK rises 1 cycle after the 4th wrap; ALL_LOCK one cycle after that.
- Write ch1 DIV=5 mid-period -> CH_PEND[1]=1 until the next ch1 wrap; then CE[1] period = 5; CLKOUT[1] = 3 high / 2 low; LOCK[1] drops at apply and re-asserts after 5x4=20 cycles. Other channels undisturbed.
- Write ch2 DIV=0, then DIV=3 -> ch2 stops at its wrap (CE=CLKOUT=LOCK=0); the DIV=3 write applies on the cycle after pend_valid rises, then runs at period 3.
- Write ch0 DIV=7 then DIV=9 on consecutive cycles before the wrap -> only 9 is applied; CFG_ERR stays 0.
- NUM_CH=3, CFG_SEL=3 -> CFG_ERR one-cycle pulse; no CH_PEND bit set; all channels unchanged.
- Write ch3 DIV=1 on ch3's wrap cycle -> the old ratio runs one more full period, then CE[3]=CLKOUT[3]=1 constantly. Assert RESETN low mid-period -> all outputs 0 asynchronously, div_act back to DEFAULT_DIV.
